frame_draw_scheduler: RTL and testbench
=======================================

FRAME_DRAW_SCHEDULER -- requirements
Module: frame_draw_scheduler

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, the triangle command queue depth (power of 2, 2..64).
REQ-002 The block SHALL have parameter BUF_A_ADDR, default 32'h0012C000, the back-buffer base after reset.
REQ-003 The block SHALL have parameter BUF_B_ADDR, default 32'h00000000, the alternate back-buffer base.
REQ-004 The block SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port frame_req  in  1  request to render one frame; a level, sampled every cycle.
REQ-007 The block SHALL have port cmd_valid  in  1  a triangle command is offered.
REQ-008 The block SHALL have port cmd_ready  out  1  the queue accepts a command (combinational: !full).
REQ-009 The block SHALL have port cmd_data  in  128  {colour[31:0], cy, cx, by, bx, ay, ax}, with 16 bits per coordinate.
REQ-010 The block SHALL have port vga_blank_n  in  1  VGA blanking; low = blanking interval.
REQ-011 The block SHALL have ports drawer_en out 1 / drawer_done in 1  start pulse to, and completion from, the draw engine.
REQ-012 The block SHALL have ports opcode out 4, ax/ay/bx/by/cx/cy out 16 each, colour out 32  draw engine operands.
REQ-013 The block SHALL have ports screen_clear out 1 and swap_buffer out 1  clear qualifier and buffer-swap pulse.
REQ-014 The block SHALL have port buffer_addr  out  32  current back-buffer base offset.
REQ-015 The block SHALL have ports busy out 1 (state != IDLE) and frame_count out 16 (completed frames, wraps at 16'hFFFF -> 0).

Function
REQ-016 The queue SHALL be a FIFO; push on cmd_valid && cmd_ready in any state; pop only in LOAD; push and pop in the same cycle SHALL keep count unchanged.
REQ-017 The FSM SHALL have states IDLE, START_CLEAR, WAIT_CLEAR, LOAD, START_TRI, WAIT_TRI, WAIT_BLANK, SWAP.
REQ-018 Transitions SHALL be: IDLE->START_CLEAR when (frame_req || pending); START_CLEAR->WAIT_CLEAR; WAIT_CLEAR->(remaining ? LOAD : WAIT_BLANK) on drawer_done; LOAD->START_TRI; START_TRI->WAIT_TRI.
REQ-019 Transitions SHALL continue: WAIT_TRI->(remaining ? LOAD : WAIT_BLANK) on drawer_done; WAIT_BLANK->SWAP when !vga_blank_n; SWAP->IDLE.
REQ-020 In START_CLEAR the block SHALL snapshot remaining = FIFO count; commands pushed afterwards belong to the next frame.
REQ-021 LOAD SHALL pop one entry into ax..cy and colour registers, and decrement remaining.
REQ-022 In START_CLEAR the block SHALL register drawer_en=1, screen_clear=1, opcode=0, colour=0; in START_TRI it SHALL register drawer_en=1, opcode=1; each for exactly one cycle.
REQ-023 drawer_en SHALL therefore be high in the first cycle of WAIT_CLEAR/WAIT_TRI; drawer_done SHALL be ignored in that cycle.
REQ-024 In SWAP the block SHALL register swap_buffer=1 for one cycle, toggle buffer_addr between BUF_A_ADDR and BUF_B_ADDR, and increment frame_count.
REQ-025 A frame_req sampled high outside IDLE SHALL set pending; multiple requests SHALL collapse into one; pending SHALL clear on entering START_CLEAR.
REQ-026 Operand outputs SHALL hold their last values between operations.
REQ-027 No timeout SHALL apply; the FSM SHALL wait indefinitely for drawer_done or blanking.

Reset
REQ-028 Reset SHALL put the FSM in IDLE and empty the FIFO.
REQ-029 Reset SHALL clear pending, remaining and frame_count to 0.
REQ-030 Reset SHALL drive drawer_en, screen_clear, swap_buffer and busy to 0, opcode to 0 and all operands to 0.
REQ-031 Reset SHALL set buffer_addr = BUF_A_ADDR.
REQ-032 Reset asserted mid-frame SHALL take effect at the next edge and SHALL discard queued commands, with no swap_buffer pulse.

Verification
REQ-033 The bench SHALL cover: empty queue, frame_req pulse -> one clear (opcode 0, colour 0), no triangle, swap when vga_blank_n=0, buffer_addr=32'h00000000, frame_count=1.
REQ-034 The bench SHALL cover: push 3 commands, frame_req -> clear, then 3 drawer_en pulses with opcode 1 and operands in push order, then one swap.
REQ-035 The bench SHALL cover: push 8 (FIFO_DEPTH) commands -> cmd_ready=0; the 9th valid is not accepted; after the first LOAD pop, cmd_ready=1.
REQ-036 The bench SHALL cover: push during WAIT_TRI of frame 1 -> excluded from frame 1 and drawn in frame 2; two frame_req pulses while busy -> exactly one extra frame.
REQ-037 The bench SHALL cover: vga_blank_n held 1 after the last drawer_done -> stays in WAIT_BLANK with swap_buffer=0; drop it to 0 -> swap_buffer pulses the next cycle.
REQ-038 The bench SHALL cover: reset asserted in WAIT_TRI with 2 queued commands -> next cycle IDLE, cmd_ready=1, buffer_addr=32'h0012C000, frame_count=0.

Source files
------------

// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - triangle command queue and per-frame clear/draw/swap sequencer
module frame_draw_scheduler #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BUF_A_ADDR = 32'h0012C000,
    parameter logic [31:0] BUF_B_ADDR = 32'h00000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         frame_req,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [127:0] cmd_data,
    input  logic         vga_blank_n,
    output logic         drawer_en,
    input  logic         drawer_done,
    output logic [3:0]   opcode,
    output logic [15:0]  ax,
    output logic [15:0]  ay,
    output logic [15:0]  bx,
    output logic [15:0]  by,
    output logic [15:0]  cx,
    output logic [15:0]  cy,
    output logic [31:0]  colour,
    output logic         screen_clear,
    output logic         swap_buffer,
    output logic [31:0]  buffer_addr,
    output logic         busy,
    output logic [15:0]  frame_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START_CLEAR,
        WAIT_CLEAR,
        LOAD,
        START_TRI,
        WAIT_TRI,
        WAIT_BLANK,
        SWAP
    } state_t;

    state_t state_q, state_d;

    logic [127:0]     mem_q [FIFO_DEPTH];
    logic [127:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             pending_q, pending_d;
    logic             drawer_en_q, drawer_en_d;
    logic             screen_clear_q, screen_clear_d;
    logic             swap_buffer_q, swap_buffer_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [15:0]      ax_q, ax_d, ay_q, ay_d, bx_q, bx_d;
    logic [15:0]      by_q, by_d, cx_q, cx_d, cy_q, cy_d;
    logic [31:0]      colour_q, colour_d;
    logic             buf_sel_q, buf_sel_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic             push;
    logic             pop;
    logic [127:0]     head;

    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == LOAD) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // Queue bookkeeping: pushes accepted in any state, pops only while loading.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = cmd_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Frame sequencer: next state, one-cycle strobes and held operand registers.
    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        pending_d      = pending_q;
        drawer_en_d    = 1'b0;
        screen_clear_d = 1'b0;
        swap_buffer_d  = 1'b0;
        opcode_d       = opcode_q;
        ax_d           = ax_q;
        ay_d           = ay_q;
        bx_d           = bx_q;
        by_d           = by_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
        colour_d       = colour_q;
        buf_sel_d      = buf_sel_q;
        frame_count_d  = frame_count_q;

        case (state_q)
            IDLE: begin
                if (frame_req || pending_q) begin
                    state_d = START_CLEAR;
                end
            end
            START_CLEAR: begin
                // Only what is queued right now belongs to this frame.
                remaining_d    = count_q;
                drawer_en_d    = 1'b1;
                screen_clear_d = 1'b1;
                opcode_d       = 4'd0;
                colour_d       = 32'd0;
                state_d        = WAIT_CLEAR;
            end
            WAIT_CLEAR, WAIT_TRI: begin
                // drawer_en_q high marks the first wait cycle; a done there is stale.
                if (drawer_done && !drawer_en_q) begin
                    state_d = (remaining_q != '0) ? LOAD : WAIT_BLANK;
                end
            end
            LOAD: begin
                if (pop) begin
                    ax_d        = head[15:0];
                    ay_d        = head[31:16];
                    bx_d        = head[47:32];
                    by_d        = head[63:48];
                    cx_d        = head[79:64];
                    cy_d        = head[95:80];
                    colour_d    = head[127:96];
                    remaining_d = remaining_q - CNT_W'(1);
                end
                state_d = START_TRI;
            end
            START_TRI: begin
                drawer_en_d = 1'b1;
                opcode_d    = 4'd1;
                state_d     = WAIT_TRI;
            end
            WAIT_BLANK: begin
                if (!vga_blank_n) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                swap_buffer_d = 1'b1;
                buf_sel_d     = !buf_sel_q;
                frame_count_d = frame_count_q + 16'd1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Requests arriving mid-frame collapse into a single follow-on frame.
        if (state_q != IDLE && frame_req) begin
            pending_d = 1'b1;
        end
        if (state_q == IDLE && state_d == START_CLEAR) begin
            pending_d = 1'b0;
        end
    end

    // Control and operand registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            remaining_q    <= '0;
            pending_q      <= 1'b0;
            drawer_en_q    <= 1'b0;
            screen_clear_q <= 1'b0;
            swap_buffer_q  <= 1'b0;
            opcode_q       <= 4'd0;
            ax_q           <= 16'd0;
            ay_q           <= 16'd0;
            bx_q           <= 16'd0;
            by_q           <= 16'd0;
            cx_q           <= 16'd0;
            cy_q           <= 16'd0;
            colour_q       <= 32'd0;
            buf_sel_q      <= 1'b0;
            frame_count_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            remaining_q    <= remaining_d;
            pending_q      <= pending_d;
            drawer_en_q    <= drawer_en_d;
            screen_clear_q <= screen_clear_d;
            swap_buffer_q  <= swap_buffer_d;
            opcode_q       <= opcode_d;
            ax_q           <= ax_d;
            ay_q           <= ay_d;
            bx_q           <= bx_d;
            by_q           <= by_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            colour_q       <= colour_d;
            buf_sel_q      <= buf_sel_d;
            frame_count_q  <= frame_count_d;
        end
    end

    // Queue storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign drawer_en    = drawer_en_q;
    assign screen_clear = screen_clear_q;
    assign swap_buffer  = swap_buffer_q;
    assign opcode       = opcode_q;
    assign ax           = ax_q;
    assign ay           = ay_q;
    assign bx           = bx_q;
    assign by           = by_q;
    assign cx           = cx_q;
    assign cy           = cy_q;
    assign colour       = colour_q;
    assign buffer_addr  = buf_sel_q ? BUF_B_ADDR : BUF_A_ADDR;
    assign busy         = (state_q != IDLE);
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - directed self-checking bench for frame_draw_scheduler
module tb_frame_draw_scheduler;

    localparam logic [31:0] BUF_A = 32'h0012C000;
    localparam logic [31:0] BUF_B = 32'h00000000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         frame_req = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [127:0] cmd_data = '0;
    logic         vga_blank_n = 1'b1;
    logic         drawer_done = 1'b0;
    logic         cmd_ready;
    logic         drawer_en;
    logic [3:0]   opcode;
    logic [15:0]  ax, ay, bx, by, cx, cy;
    logic [31:0]  colour;
    logic         screen_clear;
    logic         swap_buffer;
    logic [31:0]  buffer_addr;
    logic         busy;
    logic [15:0]  frame_count;
    logic [127:0] ops;

    int n_cmp = 0;
    int n_bad = 0;

    frame_draw_scheduler #(
        .FIFO_DEPTH (8),
        .BUF_A_ADDR (BUF_A),
        .BUF_B_ADDR (BUF_B)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_req    (frame_req),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .vga_blank_n  (vga_blank_n),
        .drawer_en    (drawer_en),
        .drawer_done  (drawer_done),
        .opcode       (opcode),
        .ax           (ax),
        .ay           (ay),
        .bx           (bx),
        .by           (by),
        .cx           (cx),
        .cy           (cy),
        .colour       (colour),
        .screen_clear (screen_clear),
        .swap_buffer  (swap_buffer),
        .buffer_addr  (buffer_addr),
        .busy         (busy),
        .frame_count  (frame_count)
    );

    assign ops = {colour, cy, cx, by, bx, ay, ax};

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_cmd(input logic [15:0] k);
        return {32'hC0DE0000 | {16'h0000, k}, 16'h6000 + k, 16'h5000 + k,
                16'h4000 + k, 16'h3000 + k, 16'h2000 + k, 16'h1000 + k};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_cmd(input logic [127:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic start_frame();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic wait_drawer(input string tag);
        int n = 0;
        while (drawer_en !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check_eq({tag, " en"}, 128'(drawer_en), 128'(1));
    endtask

    task automatic finish_op();
        tick();
        check_eq("en_pulse", 128'(drawer_en), 128'(0));
        drawer_done = 1'b1;
        tick();
        drawer_done = 1'b0;
    endtask

    task automatic wait_swap(input string tag);
        int n = 0;
        while (swap_buffer !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check_eq({tag, " swap"}, 128'(swap_buffer), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        check_eq("rst busy", 128'(busy), 128'(0));
        check_eq("rst cmd_ready", 128'(cmd_ready), 128'(1));
        check_eq("rst drawer_en", 128'(drawer_en), 128'(0));
        check_eq("rst screen_clear", 128'(screen_clear), 128'(0));
        check_eq("rst swap", 128'(swap_buffer), 128'(0));
        check_eq("rst opcode", 128'(opcode), 128'(0));
        check_eq("rst operands", ops, 128'(0));
        check_eq("rst buffer_addr", 128'(buffer_addr), 128'(BUF_A));
        check_eq("rst frame_count", 128'(frame_count), 128'(0));

        // Empty queue: one clear, no triangle, swap during blanking.
        vga_blank_n = 1'b0;
        start_frame();
        check_eq("t1 busy", 128'(busy), 128'(1));
        wait_drawer("t1 clear");
        check_eq("t1 screen_clear", 128'(screen_clear), 128'(1));
        check_eq("t1 opcode", 128'(opcode), 128'(0));
        check_eq("t1 colour", 128'(colour), 128'(0));
        drawer_done = 1'b1;
        tick();
        drawer_done = 1'b0;
        check_eq("t1 en one cycle", 128'(drawer_en), 128'(0));
        check_eq("t1 clear one cycle", 128'(screen_clear), 128'(0));
        repeat (3) tick();
        check_eq("t1 early done busy", 128'(busy), 128'(1));
        check_eq("t1 early done swap", 128'(swap_buffer), 128'(0));
        check_eq("t1 early done count", 128'(frame_count), 128'(0));
        drawer_done = 1'b1;
        tick();
        drawer_done = 1'b0;
        wait_swap("t1");
        check_eq("t1 buffer_addr", 128'(buffer_addr), 128'(BUF_B));
        check_eq("t1 frame_count", 128'(frame_count), 128'(1));
        check_eq("t1 idle", 128'(busy), 128'(0));
        check_eq("t1 no triangle", 128'(opcode), 128'(0));
        tick();
        check_eq("t1 swap one cycle", 128'(swap_buffer), 128'(0));

        // Three commands drawn in push order.
        for (int k = 0; k < 3; k++) push_cmd(mk_cmd(16'(k)));
        check_eq("t2 push no start", 128'(busy), 128'(0));
        start_frame();
        wait_drawer("t2 clear");
        check_eq("t2 clear opcode", 128'(opcode), 128'(0));
        finish_op();
        for (int i = 0; i < 3; i++) begin
            wait_drawer("t2 tri");
            check_eq("t2 tri opcode", 128'(opcode), 128'(1));
            check_eq("t2 tri no clear", 128'(screen_clear), 128'(0));
            check_eq("t2 tri operands", ops, mk_cmd(16'(i)));
            finish_op();
        end
        wait_swap("t2");
        check_eq("t2 frame_count", 128'(frame_count), 128'(2));
        check_eq("t2 buffer_addr", 128'(buffer_addr), 128'(BUF_A));

        // Full queue back-pressure, rejected ninth, ready again after first pop.
        for (int k = 0; k < 8; k++) push_cmd(mk_cmd(16'(16 + k)));
        check_eq("t3 full ready", 128'(cmd_ready), 128'(0));
        push_cmd(mk_cmd(16'd99));
        check_eq("t3 ninth rejected", 128'(cmd_ready), 128'(0));
        start_frame();
        wait_drawer("t3 clear");
        tick();
        drawer_done = 1'b1;
        tick();
        drawer_done = 1'b0;
        check_eq("t3 ready in load", 128'(cmd_ready), 128'(0));
        tick();
        check_eq("t3 ready after pop", 128'(cmd_ready), 128'(1));
        for (int i = 0; i < 8; i++) begin
            wait_drawer("t3 tri");
            check_eq("t3 tri operands", ops, mk_cmd(16'(16 + i)));
            finish_op();
        end
        wait_swap("t3");
        check_eq("t3 frame_count", 128'(frame_count), 128'(3));
        check_eq("t3 buffer_addr", 128'(buffer_addr), 128'(BUF_B));

        // Late push goes to the next frame; two busy requests give one extra frame.
        push_cmd(mk_cmd(16'd40));
        start_frame();
        wait_drawer("t4 clear");
        finish_op();
        wait_drawer("t4 tri");
        check_eq("t4 tri operands", ops, mk_cmd(16'd40));
        cmd_valid = 1'b1;
        cmd_data  = mk_cmd(16'd41);
        frame_req = 1'b1;
        tick();
        cmd_valid = 1'b0;
        frame_req = 1'b0;
        tick();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        drawer_done = 1'b1;
        tick();
        drawer_done = 1'b0;
        wait_swap("t4 f1");
        check_eq("t4 f1 frame_count", 128'(frame_count), 128'(4));
        wait_drawer("t4 f2 clear");
        check_eq("t4 f2 clear opcode", 128'(opcode), 128'(0));
        finish_op();
        wait_drawer("t4 f2 tri");
        check_eq("t4 f2 tri opcode", 128'(opcode), 128'(1));
        check_eq("t4 f2 tri operands", ops, mk_cmd(16'd41));
        finish_op();
        wait_swap("t4 f2");
        check_eq("t4 f2 frame_count", 128'(frame_count), 128'(5));
        check_eq("t4 f2 buffer_addr", 128'(buffer_addr), 128'(BUF_B));
        repeat (10) tick();
        check_eq("t4 no third frame", 128'(busy), 128'(0));
        check_eq("t4 count stable", 128'(frame_count), 128'(5));

        // Swap waits for blanking.
        vga_blank_n = 1'b1;
        start_frame();
        wait_drawer("t5 clear");
        finish_op();
        repeat (5) tick();
        check_eq("t5 hold swap", 128'(swap_buffer), 128'(0));
        check_eq("t5 hold busy", 128'(busy), 128'(1));
        check_eq("t5 hold count", 128'(frame_count), 128'(5));
        vga_blank_n = 1'b0;
        tick();
        check_eq("t5 in swap state", 128'(swap_buffer), 128'(0));
        tick();
        check_eq("t5 swap pulse", 128'(swap_buffer), 128'(1));
        check_eq("t5 frame_count", 128'(frame_count), 128'(6));
        check_eq("t5 buffer_addr", 128'(buffer_addr), 128'(BUF_A));
        tick();
        check_eq("t5 swap one cycle", 128'(swap_buffer), 128'(0));

        // Reset in WAIT_TRI with two commands still queued.
        start_frame();
        wait_drawer("t6 pre clear");
        finish_op();
        wait_swap("t6 pre");
        check_eq("t6 pre buffer_addr", 128'(buffer_addr), 128'(BUF_B));
        check_eq("t6 pre frame_count", 128'(frame_count), 128'(7));
        for (int k = 0; k < 3; k++) push_cmd(mk_cmd(16'(60 + k)));
        start_frame();
        wait_drawer("t6 clear");
        finish_op();
        wait_drawer("t6 tri");
        check_eq("t6 tri operands", ops, mk_cmd(16'd60));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6 rst busy", 128'(busy), 128'(0));
        check_eq("t6 rst cmd_ready", 128'(cmd_ready), 128'(1));
        check_eq("t6 rst buffer_addr", 128'(buffer_addr), 128'(BUF_A));
        check_eq("t6 rst frame_count", 128'(frame_count), 128'(0));
        check_eq("t6 rst drawer_en", 128'(drawer_en), 128'(0));
        check_eq("t6 rst swap", 128'(swap_buffer), 128'(0));
        check_eq("t6 rst opcode", 128'(opcode), 128'(0));
        check_eq("t6 rst operands", ops, 128'(0));
        repeat (3) tick();
        check_eq("t6 stays idle", 128'(busy), 128'(0));
        check_eq("t6 no swap", 128'(swap_buffer), 128'(0));
        start_frame();
        wait_drawer("t6 post clear");
        finish_op();
        wait_swap("t6 post");
        check_eq("t6 queue discarded", 128'(opcode), 128'(0));
        check_eq("t6 post frame_count", 128'(frame_count), 128'(1));
        check_eq("t6 post buffer_addr", 128'(buffer_addr), 128'(BUF_B));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
